cm_min_filter: RTL and testbench
================================

CM_MIN_FILTER -- requirements
Module: cm_min_filter

Interface
REQ-001 Parameter NUM_HASH, default 4: counter lanes per input, power of 2, at least 2.
REQ-002 Parameter ADDR_SIZE, default 22: address width.
REQ-003 Parameter CNT_SIZE, default 32: counter width.
REQ-004 Parameter FIFO_DEPTH, default 8: hot-address FIFO entries, power of 2.
REQ-005 Parameter DROP_CNT_SIZE, default 16: drop counter width.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 query_rst_n  input  1  synchronous active-low flush of pipeline, FIFO and drop counter.
REQ-009 in_valid  input  1  sketch result valid; no backpressure upstream.
REQ-010 in_addr  input  ADDR_SIZE  address the counters belong to.
REQ-011 in_cnt_array  input  CNT_SIZE x NUM_HASH  per-hash counters.
REQ-012 threshold  input  CNT_SIZE  hot threshold, quasi-static.
REQ-013 out_valid  output  1  FIFO head valid.
REQ-014 out_ready  input  1  consumer accepts head.
REQ-015 out_addr  output  ADDR_SIZE  hot address at FIFO head.
REQ-016 out_cnt  output  CNT_SIZE  min-count estimate at FIFO head.
REQ-017 drop_cnt  output  DROP_CNT_SIZE  hot results lost to a full FIFO.

Function
REQ-018 Input stage registers in_valid, in_addr, in_cnt_array every cycle, without gating.
REQ-019 Min-reduction is a registered pairwise tree of log2(NUM_HASH) stages; each stage takes the unsigned min of two lanes.
REQ-020 Equal lane values give that value; no tie-break state.
REQ-021 Compare stage marks a result hot when valid and min >= threshold (unsigned); threshold 0 makes every valid result hot.
REQ-022 Latency with NUM_HASH=4: input sampled at edge N; hot result written to FIFO at edge N+4; out_valid high after edge N+4 if FIFO was empty.
REQ-023 FIFO is first-word fall-through; out_addr and out_cnt reflect the head whenever out_valid=1.
REQ-024 A pop occurs on any edge with out_valid=1 and out_ready=1.
REQ-025 A push is accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-026 When a push and a pop occur on the same edge, occupancy is unchanged and order is preserved.
REQ-027 A hot result that cannot be pushed is discarded, and drop_cnt increments by 1.
REQ-028 drop_cnt saturates at all-ones.
REQ-029 Read and write pointers wrap modulo FIFO_DEPTH; occupancy counter spans 0..FIFO_DEPTH.
REQ-030 Non-hot or invalid results never touch the FIFO or drop_cnt.
REQ-031 out_addr and out_cnt hold value while out_valid=1 and out_ready=0.
REQ-032 The pipeline accepts one input every cycle; throughput is independent of out_ready.

Reset
REQ-033 rst_n low asynchronously sets every pipeline valid, FIFO pointer, occupancy and drop_cnt to 0.
REQ-034 While rst_n is low, out_valid=0, out_addr=0, out_cnt=0 and drop_cnt=0.
REQ-035 query_rst_n low at an edge has the same effect as REQ-033, applied synchronously.
REQ-036 Any in-flight result at a reset or flush is lost and not counted as a drop.
REQ-037 If rst_n and query_rst_n are both low, rst_n takes precedence.

Verification
REQ-038 Min and latency: threshold=10, in_cnt_array={40,12,99,15}, addr=0x2A -> out_valid at N+4, out_addr=0x2A, out_cnt=12.
REQ-039 Threshold boundary: threshold=12, min=12 is pushed; threshold=13, min=12 is not pushed; drop_cnt=0.
REQ-040 FIFO full: out_ready=0, 10 consecutive hot inputs, FIFO_DEPTH=8 -> 8 entries in order, drop_cnt=2; then drain delivers the 8 in order.
REQ-041 Simultaneous push and pop at full: FIFO full, out_ready=1, one hot input arrives -> pop and push both occur, occupancy stays 8, drop_cnt unchanged.
REQ-042 Saturation and flush: DROP_CNT_SIZE=2, 5 drops -> drop_cnt=3; query_rst_n pulse -> drop_cnt=0, out_valid=0 at the next edge.
REQ-043 Async reset mid-stream: rst_n asserted between edges with FIFO holding 3 entries -> out_valid=0 immediately; no output until new input +4 cycles after release.

Source files
------------

// File: rtl/cm_min_filter.sv
// Count-min result filter: registered pairwise min-reduction over the hash lanes,
// threshold compare, and a first-word fall-through FIFO of hot addresses with a drop counter.
module cm_min_filter #(
  parameter int NUM_HASH      = 4,
  parameter int ADDR_SIZE     = 22,
  parameter int CNT_SIZE      = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int DROP_CNT_SIZE = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               query_rst_n,
  input  logic                               in_valid,
  input  logic [ADDR_SIZE-1:0]               in_addr,
  input  logic [NUM_HASH-1:0][CNT_SIZE-1:0]  in_cnt_array,
  input  logic [CNT_SIZE-1:0]                threshold,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ADDR_SIZE-1:0]               out_addr,
  output logic [CNT_SIZE-1:0]                out_cnt,
  output logic [DROP_CNT_SIZE-1:0]           drop_cnt
);

  localparam int LEVELS = $clog2(NUM_HASH);
  localparam int NODES  = 2 * NUM_HASH - 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  function automatic logic [CNT_SIZE-1:0] umin(input logic [CNT_SIZE-1:0] a,
                                               input logic [CNT_SIZE-1:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Heap layout: node j has children 2j+1 and 2j+2; leaves sit at NUM_HASH-1 .. NODES-1.
  logic [NODES-1:0][CNT_SIZE-1:0]   node_r;
  logic [LEVELS:0]                  vld_r;
  logic [LEVELS:0][ADDR_SIZE-1:0]   addr_r;
  logic                             hot_r;
  logic [ADDR_SIZE-1:0]             hot_addr_r;
  logic [CNT_SIZE-1:0]              hot_cnt_r;

  logic [ADDR_SIZE-1:0]             mem_addr_r [FIFO_DEPTH];
  logic [CNT_SIZE-1:0]              mem_cnt_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]                 wr_ptr_r;
  logic [PTR_W-1:0]                 rd_ptr_r;
  logic [PTR_W:0]                   count_r;
  logic [DROP_CNT_SIZE-1:0]         drop_cnt_r;

  logic pop_s;
  logic full_s;
  logic push_s;
  logic drop_s;

  // Input capture, min tree and compare stage; every tree level is one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_r     <= '0;
      vld_r      <= '0;
      addr_r     <= '0;
      hot_r      <= 1'b0;
      hot_addr_r <= '0;
      hot_cnt_r  <= '0;
    end else if (!query_rst_n) begin
      node_r     <= '0;
      vld_r      <= '0;
      addr_r     <= '0;
      hot_r      <= 1'b0;
      hot_addr_r <= '0;
      hot_cnt_r  <= '0;
    end else begin
      vld_r  <= {vld_r[LEVELS-1:0], in_valid};
      addr_r <= {addr_r[LEVELS-1:0], in_addr};
      for (int j = 0; j < NUM_HASH - 1; j++) begin
        node_r[j] <= umin(node_r[2*j+1], node_r[2*j+2]);
      end
      for (int i = 0; i < NUM_HASH; i++) begin
        node_r[NUM_HASH-1+i] <= in_cnt_array[i];
      end
      hot_r      <= vld_r[LEVELS] && (node_r[0] >= threshold);
      hot_addr_r <= addr_r[LEVELS];
      hot_cnt_r  <= node_r[0];
    end
  end

  // FIFO handshake: a full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop_s  = (count_r != '0) && out_ready;
    full_s = (count_r == DEPTH_C);
    push_s = hot_r && (!full_s || pop_s);
    drop_s = hot_r && !push_s;
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      drop_cnt_r <= '0;
    end else if (!query_rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s && (drop_cnt_r != '1)) begin
        drop_cnt_r <= drop_cnt_r + DROP_CNT_SIZE'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= hot_addr_r;
      mem_cnt_r[wr_ptr_r]  <= hot_cnt_r;
    end
  end

  // Head presentation, forced to zero whenever the FIFO is empty.
  always_comb begin
    out_valid = (count_r != '0);
    drop_cnt  = drop_cnt_r;
    if (out_valid) begin
      out_addr = mem_addr_r[rd_ptr_r];
      out_cnt  = mem_cnt_r[rd_ptr_r];
    end else begin
      out_addr = '0;
      out_cnt  = '0;
    end
  end

endmodule

// File: tb/tb_cm_min_filter.sv
// Scoreboard bench for cm_min_filter: a queue-based reference model predicts FIFO contents and
// drops; a monitor compares the DUT head, out_valid and drop_cnt every cycle.
module tb_cm_min_filter;

  localparam int NH    = 4;
  localparam int AW    = 22;
  localparam int CW    = 32;
  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int DMAX  = (1 << DW) - 1;
  localparam int LAT   = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    query_rst_n;
  logic                    in_valid;
  logic [AW-1:0]           in_addr;
  logic [NH-1:0][CW-1:0]   in_cnt_array;
  logic [CW-1:0]           threshold;
  logic                    out_valid;
  logic                    out_ready;
  logic [AW-1:0]           out_addr;
  logic [CW-1:0]           out_cnt;
  logic [DW-1:0]           drop_cnt;

  cm_min_filter #(
    .NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CW), .FIFO_DEPTH(DEPTH), .DROP_CNT_SIZE(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .query_rst_n(query_rst_n),
    .in_valid(in_valid), .in_addr(in_addr), .in_cnt_array(in_cnt_array),
    .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_cnt(out_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } ent_t;

  ent_t pend_q[$];
  ent_t exp_q[$];
  int   mdl_drop = 0;
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: results become visible LAT edges after capture; FIFO is a plain queue.
  initial begin
    forever begin
      @(posedge clk);
      cyc_n++;
      if (!rst_n || !query_rst_n) begin
        pend_q.delete();
        exp_q.delete();
        mdl_drop = 0;
      end else begin
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (pend_q.size() > 0 && pend_q[0].due == cyc_n) begin
          ent_t e;
          e = pend_q.pop_front();
          if (exp_q.size() < DEPTH) exp_q.push_back(e);
          else if (mdl_drop < DMAX) mdl_drop++;
        end
        if (in_valid) begin
          logic [CW-1:0] mn;
          mn = in_cnt_array[0];
          for (int i = 1; i < NH; i++) if (in_cnt_array[i] < mn) mn = in_cnt_array[i];
          if (mn >= threshold) pend_q.push_back('{cyc_n + LAT, in_addr, mn});
        end
      end
    end
  end

  // Monitor: compare the presented head and counters against the model between edges.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
        chk("out_cnt", 64'(out_cnt), 64'(exp_q[0].cnt));
      end
      chk("drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                      input logic [CW-1:0] c2, input logic [CW-1:0] c3);
    in_valid = 1'b1;
    in_addr = a;
    in_cnt_array = {c3, c2, c1, c0};
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    query_rst_n = 1'b0;
    idle(1);
    query_rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    query_rst_n = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_cnt_array = '0;
    threshold = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic min and latency
    threshold = 32'd10;
    out_ready = 1'b1;
    send(22'h2A, 32'd40, 32'd12, 32'd99, 32'd15);
    idle(8);

    // Threshold boundary
    threshold = 32'd12;
    send(22'h101, 32'd12, 32'd50, 32'd12, 32'd77);
    idle(8);
    threshold = 32'd13;
    send(22'h102, 32'd12, 32'd50, 32'd12, 32'd77);
    idle(8);
    chk("boundary_drop", 64'(drop_cnt), 64'd0);

    // Fill with consumer stalled: 8 stored, 2 dropped, then drain in order
    threshold = 32'd5;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) send(22'(32'h200 + k), 32'(k + 6), 32'd100, 32'd200, 32'd300);
    idle(6);
    chk("full_drop_cnt", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    idle(12);

    // Simultaneous push and pop at full
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send(22'(32'h300 + k), 32'd50, 32'(k + 20), 32'd90, 32'd91);
    idle(6);
    send(22'h3FF, 32'd60, 32'd61, 32'd62, 32'd63);
    idle(3);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(2);
    chk("pushpop_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    idle(12);

    // Drop saturation then flush
    flush();
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 5; k++) send(22'(32'h400 + k), 32'd9, 32'd8, 32'd7, 32'(k + 6));
    idle(6);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'(DMAX));
    flush();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_drop_cnt", 64'(drop_cnt), 64'd0);
    idle(2);

    // Randomised traffic with occasional flushes
    threshold = 32'd30;
    for (int k = 0; k < 400; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      query_rst_n = ($urandom_range(0, 79) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_addr = 22'($urandom);
      for (int i = 0; i < NH; i++) in_cnt_array[i] = 32'($urandom_range(20, 63));
      @(negedge clk);
    end
    in_valid = 1'b0;
    query_rst_n = 1'b1;
    out_ready = 1'b1;
    idle(14);

    // Asynchronous reset mid-cycle with entries held
    flush();
    threshold = 32'd1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(22'(32'h500 + k), 32'd4, 32'd5, 32'd6, 32'd7);
    idle(6);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_out_addr", 64'(out_addr), 64'd0);
    chk("async_out_cnt", 64'(out_cnt), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    send(22'h3A5A5, 32'd33, 32'd22, 32'd44, 32'd55);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
